// File: rtl/stb_controller_if.sv
// stb_controller_if: signals between the store-buffer controller and the
// LSU data bus, the DCache and the FIFO datapath.
//   master : LSU/DCache side, drives req, fence and the DCache ack
//   slave  : the controller, drives acks, datapath strobes and status
// FIFO_DEPTH sets the width of stb_count and must match the controller.
interface stb_controller_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          lsudbus2stb_req;
  logic          lsudbus2stb_fence;
  logic          dcache2stb_ack;
  logic          stb2lsudbus_ack;
  logic          stb2lsudbus_fence_done;
  logic          wr_en;
  logic          rd_sel;
  logic          r_en;
  logic [CW-1:0] stb_count;
  logic          stb_busy;

  modport master (
    output lsudbus2stb_req, lsudbus2stb_fence, dcache2stb_ack,
    input  stb2lsudbus_ack, stb2lsudbus_fence_done, wr_en, rd_sel, r_en,
           stb_count, stb_busy
  );

  modport slave (
    input  lsudbus2stb_req, lsudbus2stb_fence, dcache2stb_ack,
    output stb2lsudbus_ack, stb2lsudbus_fence_done, wr_en, rd_sel, r_en,
           stb_count, stb_busy
  );
endinterface

// File: rtl/stb_controller.sv
// stb_controller: control FSM for the store-buffer FIFO datapath.
// Accepts LSU stores (zero-latency ack = FIFO write), tracks occupancy
// internally and drains entries to the DCache when the buffer reaches the
// high-water mark, sits idle too long, or a fence is raised. A fence blocks
// new stores, drains to empty and ends with a one-cycle fence_done pulse.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stb_controller_if.slave (LSU req/fence/ack, DCache ack,
//           datapath wr_en/rd_sel/r_en, stb_count, stb_busy)
module stb_controller #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HIGH_WATER    = 3,
  parameter int unsigned DRAIN_TIMEOUT = 8
) (
  input logic              clk,
  input logic              rst_n,
  stb_controller_if.slave  bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] DRAIN      = 2'd1;
  localparam logic [1:0] FENCE_DONE = 2'd2;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HW_C    = CW'(HIGH_WATER);
  localparam logic [IW-1:0] TO_C    = IW'(DRAIN_TIMEOUT);
  localparam logic [IW-1:0] TO_M1_C = IW'(DRAIN_TIMEOUT - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic          fence_seen, fence_seen_nxt;
  logic          wr, rd;

  // Gated by rst_n so a request held through reset is not acked.
  assign wr = rst_n && bus.lsudbus2stb_req && (count != DEPTH_C)
              && !bus.lsudbus2stb_fence;
  assign rd = (state == DRAIN) && bus.dcache2stb_ack;

  always_comb begin
    count_nxt = count + CW'(wr) - CW'(rd);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if ((count >= HW_C) || bus.lsudbus2stb_fence ||
              ((idle_cnt == TO_M1_C) && !wr))
            state_nxt = DRAIN;
        end else if (bus.lsudbus2stb_fence) begin
          state_nxt = FENCE_DONE;
        end
      end
      // A started drain runs to empty, regardless of the high-water mark.
      DRAIN: begin
        if (count_nxt == '0)
          state_nxt = fence_seen ? FENCE_DONE : IDLE;
      end
      FENCE_DONE: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idle_nxt = '0;
    if ((state == IDLE) && (state_nxt == IDLE) && (count != '0) && !wr)
      idle_nxt = (idle_cnt == TO_C) ? idle_cnt : idle_cnt + IW'(1);
  end

  always_comb begin
    fence_seen_nxt = fence_seen;
    if (state_nxt == FENCE_DONE)
      fence_seen_nxt = 1'b0;
    else if (bus.lsudbus2stb_fence && (state != FENCE_DONE))
      fence_seen_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      idle_cnt   <= '0;
      fence_seen <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      idle_cnt   <= idle_nxt;
      fence_seen <= fence_seen_nxt;
    end
  end

  assign bus.stb2lsudbus_ack        = wr;
  assign bus.wr_en                  = wr;
  assign bus.r_en                   = rd;
  assign bus.rd_sel                 = (state == DRAIN);
  assign bus.stb2lsudbus_fence_done = (state == FENCE_DONE);
  assign bus.stb_busy               = (state != IDLE);
  assign bus.stb_count              = count;

endmodule

// File: tb/tb_stb_controller.sv
module tb_stb_controller;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HW    = 3;
  localparam int unsigned DT    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stb_controller_if #(.FIFO_DEPTH(DEPTH)) bus ();

  stb_controller #(
    .FIFO_DEPTH(DEPTH),
    .HIGH_WATER(HW),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: occupancy plus "draining"/"pulse" flags.
  int m_cnt, m_idle;
  bit m_drain, m_done, m_fpend;

  // Outputs sampled in the most recent cycle.
  bit s_ack, s_rd, s_ren, s_busy, s_fd;
  int s_cnt;

  typedef struct {
    bit req, fence, dack;
    bit ack, rd, ren;
    int cnt;
    bit busy, fd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idle = 0; m_drain = 0; m_done = 0; m_fpend = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.lsudbus2stb_req = 1'b0;
    bus.lsudbus2stb_fence = 1'b0;
    bus.dcache2stb_ack = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Called at posedge+1; samples mid-cycle, then advances the model.
  task automatic cycle(input bit req, input bit fence, input bit dack);
    bit acc, pop, enter_done, nxt_drain;
    int new_cnt;
    bus.lsudbus2stb_req = req;
    bus.lsudbus2stb_fence = fence;
    bus.dcache2stb_ack = dack;
    #3;
    acc = req && (m_cnt < int'(DEPTH)) && !fence;
    pop = m_drain && dack;
    s_ack = bus.stb2lsudbus_ack; s_rd = bus.rd_sel; s_ren = bus.r_en;
    s_busy = bus.stb_busy; s_fd = bus.stb2lsudbus_fence_done;
    s_cnt = int'(bus.stb_count);
    chk("ack", 32'(s_ack), 32'(acc));
    chk("wr_en", 32'(bus.wr_en), 32'(acc));
    chk("rd_sel", 32'(s_rd), 32'(m_drain));
    chk("r_en", 32'(s_ren), 32'(pop));
    chk("stb_count", 32'(s_cnt), 32'(m_cnt));
    chk("stb_busy", 32'(s_busy), 32'(m_drain || m_done));
    chk("fence_done", 32'(s_fd), 32'(m_done));
    @(posedge clk); #1;
    new_cnt = m_cnt + int'(acc) - int'(pop);
    enter_done = 0;
    nxt_drain = m_drain;
    if (m_done) nxt_drain = 0;
    else if (m_drain) begin
      if (new_cnt == 0) begin nxt_drain = 0; enter_done = m_fpend; end
    end else if (m_cnt != 0) begin
      if (m_cnt >= int'(HW) || fence || (!acc && m_idle >= int'(DT) - 1))
        nxt_drain = 1;
    end else if (fence) enter_done = 1;
    if (!m_drain && !m_done && !nxt_drain && m_cnt != 0 && !acc)
      m_idle = (m_idle < int'(DT)) ? m_idle + 1 : int'(DT);
    else
      m_idle = 0;
    if (enter_done) m_fpend = 0;
    else if (fence && !m_done) m_fpend = 1;
    m_done = enter_done;
    m_drain = nxt_drain;
    m_cnt = new_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    int first, rp, fp;
    bit fence_on;

    tbl[0]  = '{1,0,0, 1,0,0,0,0,0};
    tbl[1]  = '{1,0,0, 1,0,0,1,0,0};
    tbl[2]  = '{1,0,0, 1,0,0,2,0,0};
    tbl[3]  = '{1,0,0, 1,0,0,3,0,0};
    tbl[4]  = '{1,0,0, 0,1,0,4,1,0};
    tbl[5]  = '{1,0,0, 0,1,0,4,1,0};
    tbl[6]  = '{1,0,1, 0,1,1,4,1,0};
    tbl[7]  = '{1,0,0, 1,1,0,3,1,0};
    tbl[8]  = '{0,0,1, 0,1,1,4,1,0};
    tbl[9]  = '{0,0,1, 0,1,1,3,1,0};
    tbl[10] = '{0,0,1, 0,1,1,2,1,0};
    tbl[11] = '{0,0,1, 0,1,1,1,1,0};
    tbl[12] = '{0,0,1, 0,0,0,0,0,0};
    tbl[13] = '{1,1,0, 0,0,0,0,0,0};
    tbl[14] = '{0,0,0, 0,0,0,0,1,1};
    tbl[15] = '{0,0,0, 0,0,0,0,0,0};

    // Reset with req held: every output low.
    rst_n = 1'b0;
    bus.lsudbus2stb_req = 1'b1;
    bus.lsudbus2stb_fence = 1'b0;
    bus.dcache2stb_ack = 1'b1;
    model_reset();
    @(posedge clk); #2;
    chk("rst_ack", 32'(bus.stb2lsudbus_ack), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_r_en", 32'(bus.r_en), 0);
    chk("rst_rd_sel", 32'(bus.rd_sel), 0);
    chk("rst_count", 32'(bus.stb_count), 0);
    chk("rst_busy", 32'(bus.stb_busy), 0);
    chk("rst_fence_done", 32'(bus.stb2lsudbus_fence_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table: fill to full, back-pressure, pop, drain, empty fence.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].req, tbl[i].fence, tbl[i].dack);
      chk($sformatf("tbl%0d_ack", i), 32'(s_ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_rd_sel", i), 32'(s_rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_r_en", i), 32'(s_ren), 32'(tbl[i].ren));
      chk($sformatf("tbl%0d_count", i), 32'(s_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_fd", i), 32'(s_fd), 32'(tbl[i].fd));
    end

    // Idle timeout: drain starts DT edges after the write edge.
    do_reset();
    cycle(1, 0, 0);
    first = -1;
    for (int j = 0; j < 20; j++) begin
      cycle(0, 0, 0);
      if (s_rd) begin first = j; break; end
    end
    chk("timeout_edges", 32'(first), 32'(DT));
    cycle(0, 0, 1);
    chk("timeout_r_en", 32'(s_ren), 1);
    cycle(0, 0, 0);
    chk("timeout_count", 32'(s_cnt), 0);
    chk("timeout_rd_sel", 32'(s_rd), 0);
    chk("timeout_busy", 32'(s_busy), 0);

    // Fence with two entries and req held.
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    rp = 0; fp = 0;
    for (int j = 0; j < 30; j++) begin
      cycle(1, 1, 1);
      chk("fence_ack_low", 32'(s_ack), 0);
      rp += int'(s_ren);
      fp += int'(s_fd);
      if (s_fd) break;
    end
    cycle(0, 0, 0);
    fp += int'(s_fd);
    chk("fence_pops", 32'(rp), 2);
    chk("fence_done_pulses", 32'(fp), 1);
    chk("fence_count", 32'(s_cnt), 0);

    // Fence on an empty buffer.
    do_reset();
    cycle(0, 1, 0);
    chk("efence_fd0", 32'(s_fd), 0);
    chk("efence_rd0", 32'(s_rd), 0);
    cycle(0, 1, 0);
    chk("efence_fd1", 32'(s_fd), 1);
    chk("efence_rd1", 32'(s_rd), 0);
    cycle(0, 0, 0);
    chk("efence_fd2", 32'(s_fd), 0);
    chk("efence_rd2", 32'(s_rd), 0);

    // Asynchronous reset in DRAIN with count=2.
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("pre_rst_count", 32'(bus.stb_count), 2);
    bus.dcache2stb_ack = 1'b1;
    #2;
    chk("pre_rst_r_en", 32'(bus.r_en), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rd_sel", 32'(bus.rd_sel), 0);
    chk("async_r_en", 32'(bus.r_en), 0);
    chk("async_busy", 32'(bus.stb_busy), 0);
    chk("async_count", 32'(bus.stb_count), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(0, 0, 1);
    chk("stray_ack_r_en", 32'(s_ren), 0);
    chk("stray_ack_count", 32'(s_cnt), 0);

    // Random traffic against the model; fences held until their pulse.
    do_reset();
    fence_on = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!fence_on && $urandom_range(0, 39) == 0) fence_on = 1;
      cycle($urandom_range(0, 2) != 0, fence_on, $urandom_range(0, 1) == 1);
      if (s_fd) fence_on = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
